// File: rtl/ripple_mon_pkg.sv
// Shared defaults and types for the ripple counter monitor.
package ripple_mon_pkg;

  localparam int CNT_W_DEF         = 4;
  localparam int EXT_W_DEF         = 8;
  localparam int STABLE_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    TRACK = 2'd2
  } monState_t;

  // Extended count at the default widths: {ext, low}
  typedef logic [CNT_W_DEF+EXT_W_DEF-1:0] extCount_t;

endpackage

// File: rtl/ripple_sync_filter.sv
// Two-flop synchronizer for the asynchronous ripple count, followed by a
// stability filter that only releases a value once it has been seen on
// STABLE_CYCLES consecutive synchronized samples. acc_valid pulses once per
// settled candidate; short ripple transients never reach the pulse.
module ripple_sync_filter #(
  parameter int CNT_W         = 4,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_in,
  output logic             acc_valid,
  output logic [CNT_W-1:0] acc_value
);

  localparam int SC_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam int SC_N = (STABLE_CYCLES < 1) ? 1 : STABLE_CYCLES;

  logic [CNT_W-1:0] s1, s2, lastS2;
  logic [SC_W-1:0]  stableCnt;

  // Sync chain plus run-length of identical synchronized samples; the
  // counter saturates one past the accept point so the pulse fires once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1        <= '0;
      s2        <= '0;
      lastS2    <= '0;
      stableCnt <= '0;
    end else begin
      s1     <= count_in;
      s2     <= s1;
      lastS2 <= s2;
      if (s2 != lastS2)
        stableCnt <= '0;
      else if (stableCnt != SC_W'(SC_N))
        stableCnt <= stableCnt + 1'b1;
    end
  end

  // stableCnt==N-1 means lastS2 has now been sampled N times in a row
  assign acc_valid = (stableCnt == SC_W'(SC_N - 1));
  assign acc_value = lastS2;

endmodule

// File: rtl/ripple_count_monitor.sv
// Consumer of the 4-bit ripple up-counter: filters the count into the clock
// domain, extends it with wrap tracking, and offers {ext, low} downstream on a
// valid/ready interface with wrap pulse and sticky match/lost/overflow flags.
module ripple_count_monitor
  import ripple_mon_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int EXT_W         = EXT_W_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CNT_W-1:0]       count_in,
  input  logic                   enable,
  input  logic [CNT_W+EXT_W-1:0] target,
  input  logic                   match_clear,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [CNT_W+EXT_W-1:0] out_count,
  output logic                   wrap_pulse,
  output logic                   match,
  output logic                   lost,
  output logic                   ext_ovf
);

  localparam int OUT_W = CNT_W + EXT_W;

  monState_t        state, stateNext;
  logic             accValid;
  logic [CNT_W-1:0] accValue;
  logic [CNT_W-1:0] prevCnt;
  logic [EXT_W-1:0] ext, extLoad;
  logic [OUT_W-1:0] countNext;
  logic             load, isWrap;

  ripple_sync_filter #(
    .CNT_W        (CNT_W),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) uFilter (
    .clock    (clock),
    .reset    (reset),
    .count_in (count_in),
    .acc_valid(accValid),
    .acc_value(accValue)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next state and load decision; dropping enable overrides everything and
  // suppresses any load on that edge.
  always_comb begin
    stateNext = state;
    load      = 1'b0;
    isWrap    = 1'b0;
    extLoad   = ext;
    case (state)
      IDLE: if (enable) stateNext = PRIME;
      PRIME: begin
        if (accValid) begin
          load      = 1'b1;
          stateNext = TRACK;
        end
        extLoad = '0;
      end
      TRACK: begin
        if (accValid && (accValue != prevCnt)) begin
          load   = 1'b1;
          isWrap = (accValue < prevCnt);
        end
        extLoad = ext + EXT_W'(isWrap);
      end
      default: stateNext = IDLE;
    endcase
    if (!enable) begin
      stateNext = IDLE;
      load      = 1'b0;
      isWrap    = 1'b0;
      extLoad   = ext;
    end
    countNext = {extLoad, accValue};
  end

  // Tracking registers, handshake and sticky flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prevCnt    <= '0;
      ext        <= '0;
      out_valid  <= 1'b0;
      out_count  <= '0;
      wrap_pulse <= 1'b0;
      match      <= 1'b0;
      lost       <= 1'b0;
      ext_ovf    <= 1'b0;
    end else begin
      wrap_pulse <= load && isWrap;
      if (load) begin
        prevCnt   <= accValue;
        ext       <= extLoad;
        out_count <= countNext;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) lost <= 1'b1;
        if (isWrap && (ext == '1))   ext_ovf <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (load && (countNext == target)) match <= 1'b1;
      else if (match_clear)              match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor: table of settled count values with
// expected outputs, plus hand sequences for latency, backpressure, glitches,
// match set/clear, extension overflow and asynchronous reset.
module tb_ripple_count_monitor;
  import ripple_mon_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  count_in;
  logic        enable;
  extCount_t   target;
  logic        match_clear;
  logic        out_ready;
  logic        out_valid;
  extCount_t   out_count;
  logic        wrap_pulse;
  logic        match;
  logic        lost;
  logic        ext_ovf;

  int total = 0;
  int bad   = 0;

  ripple_count_monitor dut (
    .clock      (clock),
    .reset      (reset),
    .count_in   (count_in),
    .enable     (enable),
    .target     (target),
    .match_clear(match_clear),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_count  (out_count),
    .wrap_pulse (wrap_pulse),
    .match      (match),
    .lost       (lost),
    .ext_ovf    (ext_ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] cnt;
    extCount_t  expCount;
    logic       expValid;
    logic       expWrap;
    logic       expLost;
    logic       expOvf;
  } row_t;

  row_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive a settled count and sample just after the edge where it loads
  task automatic settle(input logic [3:0] v);
    count_in = v;
    repeat (5) @(negedge clock);
  endtask

  task automatic runRow(input int i);
    settle(tbl[i].cnt);
    chk($sformatf("row%0d_count", i), 32'(out_count), 32'(tbl[i].expCount));
    chk($sformatf("row%0d_valid", i), 32'(out_valid), 32'(tbl[i].expValid));
    chk($sformatf("row%0d_wrap", i),  32'(wrap_pulse), 32'(tbl[i].expWrap));
    chk($sformatf("row%0d_lost", i),  32'(lost), 32'(tbl[i].expLost));
    chk($sformatf("row%0d_ovf", i),   32'(ext_ovf), 32'(tbl[i].expOvf));
  endtask

  initial begin
    //          cnt    count    vld   wrap  lost  ovf
    tbl[0] = '{4'd4,  12'h004, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'd9,  12'h009, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{4'd14, 12'h00E, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{4'd1,  12'h011, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{4'd1,  12'h011, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{4'd0,  12'h020, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{4'd15, 12'h02F, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{4'd2,  12'h032, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b0; count_in = 4'd0; enable = 1'b0; target = 12'hFFF;
    match_clear = 1'b0; out_ready = 1'b1;

    // reset state
    #3;
    chk("reset_outs", 32'({out_valid, out_count, wrap_pulse, match, lost, ext_ovf}), 32'd0);
    chk("reset_state", 32'(dut.state == IDLE), 32'd1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    chk("idle_no_valid", 32'(out_valid), 32'd0);

    // prime: settled change produces out_valid on the fifth edge
    enable = 1'b1; count_in = 4'd3;
    repeat (4) @(negedge clock);
    chk("prime_edge4_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    chk("prime_edge5_valid", 32'(out_valid), 32'd1);
    chk("prime_count", 32'(out_count), 32'h003);
    chk("prime_wrap", 32'(wrap_pulse), 32'd0);

    runRow(0);

    // backpressure: 5 then 6 unconsumed, latest wins and lost is set
    @(negedge clock);
    chk("bp_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    settle(4'd5);
    chk("bp_first_count", 32'(out_count), 32'h005);
    chk("bp_first_lost", 32'(lost), 32'd0);
    settle(4'd6);
    chk("bp_second_count", 32'(out_count), 32'h006);
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_lost", 32'(lost), 32'd1);
    @(negedge clock);
    chk("bp_hold_count", 32'(out_count), 32'h006);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_one_transfer", 32'(out_valid), 32'd0);

    for (int i = 1; i < 8; i++) runRow(i);

    // glitch: one-clock dip to 0 must be filtered out
    settle(4'd7);
    chk("glitch_pre_count", 32'(out_count), 32'h037);
    @(negedge clock);
    count_in = 4'd0;
    @(negedge clock);
    count_in = 4'd7;
    begin
      logic seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clock);
        if (out_valid || wrap_pulse) seen = 1'b1;
      end
      chk("glitch_quiet", 32'(seen), 32'd0);
    end
    chk("glitch_count", 32'(out_count), 32'h037);

    // match set, set-beats-clear, clear alone
    target = 12'h039;
    chk("match_pre", 32'(match), 32'd0);
    settle(4'd9);
    chk("match_set", 32'(match), 32'd1);
    target = 12'h03A; count_in = 4'd10;
    repeat (4) @(negedge clock);
    match_clear = 1'b1;
    @(negedge clock);
    match_clear = 1'b0;
    chk("match_set_wins_count", 32'(out_count), 32'h03A);
    chk("match_set_wins", 32'(match), 32'd1);
    match_clear = 1'b1;
    @(negedge clock);
    match_clear = 1'b0;
    chk("match_cleared", 32'(match), 32'd0);

    // drive ext from 3 up to 0xFF, then one more wrap overflows it
    target = 12'hFFF;
    for (int k = 0; k < 252; k++) begin
      settle(4'd14);
      settle(4'd1);
    end
    chk("ext_ff_count", 32'(out_count), 32'hFF1);
    chk("ext_ff_ovf", 32'(ext_ovf), 32'd0);
    settle(4'd14);
    settle(4'd1);
    chk("ovf_count", 32'(out_count), 32'h001);
    chk("ovf_wrap", 32'(wrap_pulse), 32'd1);
    chk("ovf_flag", 32'(ext_ovf), 32'd1);

    // asynchronous reset mid-operation
    target = 12'h013;
    settle(4'd0);
    chk("pre_rst_wrap_count", 32'(out_count), 32'h010);
    @(negedge clock);
    out_ready = 1'b0;
    settle(4'd3);
    chk("pre_rst_state", 32'({out_valid, out_count, match}), 32'({1'b1, 12'h013, 1'b1}));
    #2 reset = 1'b0;
    #1;
    chk("async_rst_outs", 32'({out_valid, out_count, wrap_pulse, match, lost, ext_ovf}), 32'd0);
    enable = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("post_rst_state", 32'(dut.state == IDLE), 32'd1);
    @(negedge clock);
    chk("post_rst_idle", 32'(dut.state == IDLE), 32'd1);
    chk("post_rst_outs", 32'({out_valid, out_count, match, lost, ext_ovf}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
